// File: rtl/ctrl_pkg.sv
// Shared decode/control definitions for the registered decode stage:
// opcodes, ALU function codes, FSM states and the decoded-control bundle.
package ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        FnAdd     = 4'd0,
        FnSub     = 4'd1,
        FnAddi    = 4'd2,
        FnMul     = 4'd3,
        FnDiv     = 4'd4,
        FnRem     = 4'd5,
        FnSll     = 4'd6,
        FnSrl     = 4'd7,
        FnAnd     = 4'd8,
        FnOr      = 4'd9,
        FnXor     = 4'd10,
        FnLw      = 4'd11,
        FnSw      = 4'd12,
        FnBeq     = 4'd13,
        FnBne     = 4'd14,
        FnIllegal = 4'd15
    } func_e;

    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StBusy = 2'd1,
        StHalt = 2'd2
    } state_e;

    typedef struct packed {
        logic  beq;
        logic  result_src;
        logic  mem_write;
        logic  alu_src;
        logic  imm_src;
        logic  reg_write;
        logic  illegal;
        logic  is_mul;
        logic  is_div;
        logic  is_ret;
        func_e fn;
    } dec_t;

    function automatic dec_t dec_illegal();
        dec_t d;
        d         = '0;
        d.illegal = 1'b1;
        d.fn      = FnIllegal;
        return d;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode/func3/func7 decode into E-stage controls.
// Anything not explicitly listed decodes as illegal.
module control_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned ENABLE_M = 1
) (
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_func3,
    input  logic [6:0] i_func7,
    output dec_t       o_dec
);

    func_e w_rfn;

    always_comb begin
        o_dec = dec_illegal();
        w_rfn = FnIllegal;

        case ({i_func7, i_func3})
            {F7_BASE, 3'b000}:   w_rfn = FnAdd;
            {F7_ALT, 3'b000}:    w_rfn = FnSub;
            {F7_BASE, 3'b001}:   w_rfn = FnSll;
            {F7_BASE, 3'b101}:   w_rfn = FnSrl;
            {F7_BASE, 3'b111}:   w_rfn = FnAnd;
            {F7_BASE, 3'b110}:   w_rfn = FnOr;
            {F7_BASE, 3'b100}:   w_rfn = FnXor;
            {F7_MULDIV, 3'b000}: w_rfn = (ENABLE_M != 0) ? FnMul : FnIllegal;
            {F7_MULDIV, 3'b100}: w_rfn = (ENABLE_M != 0) ? FnDiv : FnIllegal;
            {F7_MULDIV, 3'b110}: w_rfn = (ENABLE_M != 0) ? FnRem : FnIllegal;
            default:             w_rfn = FnIllegal;
        endcase

        // imm_src: 1 selects the I/S immediate path, 0 the branch offset.
        case (i_opcode)
            OP_R: begin
                if (w_rfn != FnIllegal) begin
                    o_dec           = '0;
                    o_dec.fn        = w_rfn;
                    o_dec.reg_write = 1'b1;
                    o_dec.is_mul    = (w_rfn == FnMul);
                    o_dec.is_div    = (w_rfn == FnDiv) || (w_rfn == FnRem);
                end
            end
            OP_I: begin
                if (i_func3 == 3'b000) begin
                    o_dec           = '0;
                    o_dec.fn        = FnAddi;
                    o_dec.alu_src   = 1'b1;
                    o_dec.imm_src   = 1'b1;
                    o_dec.reg_write = 1'b1;
                end
            end
            OP_B: begin
                if (i_func3 == 3'b000 || i_func3 == 3'b001) begin
                    o_dec     = '0;
                    o_dec.fn  = (i_func3 == 3'b000) ? FnBeq : FnBne;
                    o_dec.beq = 1'b1;
                end
            end
            OP_LW: begin
                if (i_func3 == 3'b010) begin
                    o_dec            = '0;
                    o_dec.fn         = FnLw;
                    o_dec.result_src = 1'b1;
                    o_dec.alu_src    = 1'b1;
                    o_dec.imm_src    = 1'b1;
                    o_dec.reg_write  = 1'b1;
                end
            end
            OP_S: begin
                if (i_func3 == 3'b010) begin
                    o_dec           = '0;
                    o_dec.fn        = FnSw;
                    o_dec.mem_write = 1'b1;
                    o_dec.alu_src   = 1'b1;
                    o_dec.imm_src   = 1'b1;
                end
            end
            OP_SYS: begin
                if (i_func3 == 3'b000) begin
                    o_dec        = '0;
                    o_dec.fn     = FnAdd;
                    o_dec.is_ret = 1'b1;
                end
            end
            default: o_dec = dec_illegal();
        endcase
    end

endmodule

// File: rtl/control_unit_pipe.sv
// Registered decode/control stage: captures decoded controls into E, stalls D
// for multi-cycle M-extension ops and parks in a sticky halt on traps.
module control_unit_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned DIV_LAT  = 8,
    parameter int unsigned ENABLE_M = 1,
    parameter int unsigned FUNC_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic              flush,
    output logic              e_valid,
    output logic              e_beq,
    output logic              e_result_src,
    output logic              e_mem_write,
    output logic [FUNC_W-1:0] e_function,
    output logic              e_alu_src,
    output logic              e_imm_src,
    output logic              e_reg_write,
    output logic              e_illegal,
    output logic              stall_d,
    output logic              halted
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    typedef struct packed {
        logic              valid;
        logic              beq;
        logic              result_src;
        logic              mem_write;
        logic [FUNC_W-1:0] fn;
        logic              alu_src;
        logic              imm_src;
        logic              reg_write;
        logic              illegal;
    } e_reg_t;

    dec_t             w_dec;
    e_reg_t           w_cap;
    e_reg_t           r_e;
    e_reg_t           w_e_d;
    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    control_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .i_opcode (opcode),
        .i_func3  (func3),
        .i_func7  (func7),
        .o_dec    (w_dec)
    );

    always_comb begin
        w_cap            = '0;
        w_cap.valid      = 1'b1;
        w_cap.beq        = w_dec.beq;
        w_cap.result_src = w_dec.result_src;
        w_cap.mem_write  = w_dec.mem_write;
        w_cap.fn         = w_dec.illegal ? {FUNC_W{1'b1}} : FUNC_W'(w_dec.fn);
        w_cap.alu_src    = w_dec.alu_src;
        w_cap.imm_src    = w_dec.imm_src;
        w_cap.reg_write  = w_dec.reg_write;
        w_cap.illegal    = w_dec.illegal;
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_e_d     = r_e;

        unique case (r_state)
            StRun: begin
                if (flush || !dec_valid) begin
                    w_e_d = '0;
                end else begin
                    w_e_d = w_cap;
                    if (w_dec.illegal || w_dec.is_ret) begin
                        w_state_d = StHalt;
                    end else if (w_dec.is_mul && (MUL_LAT > 1)) begin
                        w_state_d = StBusy;
                        w_cnt_d   = CNT_W'(MUL_LAT - 1);
                    end else if (w_dec.is_div && (DIV_LAT > 1)) begin
                        w_state_d = StBusy;
                        w_cnt_d   = CNT_W'(DIV_LAT - 1);
                    end
                end
            end
            // E holds the multi-cycle op; D inputs are ignored until the count expires.
            StBusy: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_d = StRun;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            StHalt: begin
                w_e_d = '0;
            end
            default: begin
                w_state_d = StRun;
                w_cnt_d   = '0;
                w_e_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StRun;
            r_cnt   <= '0;
            r_e     <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_e     <= w_e_d;
        end
    end

    assign e_valid      = r_e.valid;
    assign e_beq        = r_e.beq;
    assign e_result_src = r_e.result_src;
    assign e_mem_write  = r_e.mem_write;
    assign e_function   = r_e.fn;
    assign e_alu_src    = r_e.alu_src;
    assign e_imm_src    = r_e.imm_src;
    assign e_reg_write  = r_e.reg_write;
    assign e_illegal    = r_e.illegal;
    assign stall_d      = (r_state != StRun);
    assign halted       = (r_state == StHalt);

endmodule

// File: tb/tb_control_unit_pipe.sv
// Scoreboard bench: a table-driven reference model predicts E-stage outputs,
// a negedge monitor compares them against the DUT.
module tb_control_unit_pipe;

    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned DIV_LAT = 8;
    localparam bit          M_ON    = 1'b1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dec_valid = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic [6:0] func7 = '0;
    logic       flush = 1'b0;
    logic       e_valid, e_beq, e_result_src, e_mem_write, e_alu_src, e_imm_src;
    logic       e_reg_write, e_illegal, stall_d, halted;
    logic [3:0] e_function;

    logic       n_reset = 1'b1;
    logic       n_dv = 1'b0;
    logic [6:0] n_op = '0;
    logic [2:0] n_f3 = '0;
    logic [6:0] n_f7 = '0;
    logic       n_valid, n_beq, n_rs, n_mw, n_as, n_is, n_rw, n_ill, n_stall, n_halted;
    logic [3:0] n_fn;

    always #5 clk = ~clk;

    control_unit_pipe #(
        .MUL_LAT (MUL_LAT), .DIV_LAT (DIV_LAT), .ENABLE_M (1), .FUNC_W (4)
    ) u_dut (
        .clk (clk), .reset (reset), .dec_valid (dec_valid), .opcode (opcode),
        .func3 (func3), .func7 (func7), .flush (flush), .e_valid (e_valid),
        .e_beq (e_beq), .e_result_src (e_result_src), .e_mem_write (e_mem_write),
        .e_function (e_function), .e_alu_src (e_alu_src), .e_imm_src (e_imm_src),
        .e_reg_write (e_reg_write), .e_illegal (e_illegal), .stall_d (stall_d),
        .halted (halted)
    );

    control_unit_pipe #(
        .MUL_LAT (3), .DIV_LAT (8), .ENABLE_M (0), .FUNC_W (4)
    ) u_dut_nm (
        .clk (clk), .reset (n_reset), .dec_valid (n_dv), .opcode (n_op),
        .func3 (n_f3), .func7 (n_f7), .flush (1'b0), .e_valid (n_valid),
        .e_beq (n_beq), .e_result_src (n_rs), .e_mem_write (n_mw),
        .e_function (n_fn), .e_alu_src (n_as), .e_imm_src (n_is),
        .e_reg_write (n_rw), .e_illegal (n_ill), .stall_d (n_stall),
        .halted (n_halted)
    );

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         f7_any;
        bit         m_ext;
        logic [3:0] fn;
        bit         rw, as_, is_, rs, mw, beq;
    } row_t;

    row_t        tbl[$];
    logic [13:0] expq[$];
    logic [13:0] exp_v;
    logic [13:0] got_v;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    // Model state: E contents, remaining busy edges, sticky halt.
    logic [11:0] m_e;
    int          m_busy;
    bit          m_halt;

    assign got_v = {e_valid, e_beq, e_result_src, e_mem_write, e_function,
                    e_alu_src, e_imm_src, e_reg_write, e_illegal, stall_d, halted};

    always @(negedge clk) begin
        cyc++;
        if (expq.size() > 0) begin
            exp_v = expq.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL e_stage cyc=%0d got=%h exp=%h", cyc, got_v, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic add_row(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input bit any, input bit m, input logic [3:0] fn,
                           input bit rw, input bit as_, input bit is_, input bit rs,
                           input bit mw, input bit beq);
        row_t r;
        r.op = op; r.f3 = f3; r.f7 = f7; r.f7_any = any; r.m_ext = m; r.fn = fn;
        r.rw = rw; r.as_ = as_; r.is_ = is_; r.rs = rs; r.mw = mw; r.beq = beq;
        tbl.push_back(r);
    endtask

    task automatic build_table();
        add_row(7'b0110011, 3'b000, 7'h00, 0, 0, 4'd0,  1, 0, 0, 0, 0, 0);
        add_row(7'b0110011, 3'b000, 7'h20, 0, 0, 4'd1,  1, 0, 0, 0, 0, 0);
        add_row(7'b0110011, 3'b001, 7'h00, 0, 0, 4'd6,  1, 0, 0, 0, 0, 0);
        add_row(7'b0110011, 3'b101, 7'h00, 0, 0, 4'd7,  1, 0, 0, 0, 0, 0);
        add_row(7'b0110011, 3'b111, 7'h00, 0, 0, 4'd8,  1, 0, 0, 0, 0, 0);
        add_row(7'b0110011, 3'b110, 7'h00, 0, 0, 4'd9,  1, 0, 0, 0, 0, 0);
        add_row(7'b0110011, 3'b100, 7'h00, 0, 0, 4'd10, 1, 0, 0, 0, 0, 0);
        add_row(7'b0110011, 3'b000, 7'h01, 0, 1, 4'd3,  1, 0, 0, 0, 0, 0);
        add_row(7'b0110011, 3'b100, 7'h01, 0, 1, 4'd4,  1, 0, 0, 0, 0, 0);
        add_row(7'b0110011, 3'b110, 7'h01, 0, 1, 4'd5,  1, 0, 0, 0, 0, 0);
        add_row(7'b0010011, 3'b000, 7'h00, 1, 0, 4'd2,  1, 1, 1, 0, 0, 0);
        add_row(7'b1100011, 3'b000, 7'h00, 1, 0, 4'd13, 0, 0, 0, 0, 0, 1);
        add_row(7'b1100011, 3'b001, 7'h00, 1, 0, 4'd14, 0, 0, 0, 0, 0, 1);
        add_row(7'b0000011, 3'b010, 7'h00, 1, 0, 4'd11, 1, 1, 1, 1, 0, 0);
        add_row(7'b0100011, 3'b010, 7'h00, 1, 0, 4'd12, 0, 1, 1, 0, 1, 0);
        add_row(7'b1110011, 3'b000, 7'h00, 1, 0, 4'd0,  0, 0, 0, 0, 0, 0);
    endtask

    task automatic ref_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           output logic [11:0] e, output bit halt, output int lat);
        e    = {1'b1, 3'b000, 4'hF, 4'b0001};
        halt = 1'b1;
        lat  = 1;
        foreach (tbl[i]) begin
            if (tbl[i].op == op && tbl[i].f3 == f3 && (tbl[i].f7_any || tbl[i].f7 == f7)
                && (!tbl[i].m_ext || M_ON)) begin
                e    = {1'b1, tbl[i].beq, tbl[i].rs, tbl[i].mw, tbl[i].fn,
                        tbl[i].as_, tbl[i].is_, tbl[i].rw, 1'b0};
                halt = (op == 7'b1110011);
                lat  = (tbl[i].fn == 4'd3) ? MUL_LAT :
                       (tbl[i].fn == 4'd4 || tbl[i].fn == 4'd5) ? DIV_LAT : 1;
            end
        end
    endtask

    task automatic model_reset();
        m_e    = '0;
        m_busy = 0;
        m_halt = 1'b0;
    endtask

    task automatic model_edge(input bit dv, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input bit fl);
        logic [11:0] e;
        bit          h;
        int          lat;
        if (m_halt) begin
            m_e = '0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (fl || !dv) begin
            m_e = '0;
        end else begin
            ref_dec(op, f3, f7, e, h, lat);
            m_e = e;
            if (h) m_halt = 1'b1;
            else   m_busy = lat - 1;
        end
    endtask

    // Called at posedge+1: apply inputs, publish what E should show now, advance one edge.
    task automatic step(input bit r, input bit dv, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input bit fl);
        bit s;
        reset = r; dec_valid = dv; opcode = op; func3 = f3; func7 = f7; flush = fl;
        if (r) model_reset();
        s = (m_busy > 0) || m_halt;
        expq.push_back({m_e, s, m_halt});
        @(posedge clk);
        #1;
        if (!r) model_edge(dv, op, f3, f7, fl);
    endtask

    task automatic ins(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input bit fl);
        step(1'b0, 1'b1, op, f3, f7, fl);
    endtask

    task automatic rand_instr(output logic [6:0] op, output logic [2:0] f3,
                              output logic [6:0] f7);
        int r = $urandom_range(0, 99);
        int idx;
        if (r < 90) begin
            idx = r % 15;
            op  = tbl[idx].op;
            f3  = tbl[idx].f3;
            f7  = tbl[idx].f7_any ? 7'($urandom) : tbl[idx].f7;
        end else if (r < 96) begin
            op = 7'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
        end else begin
            op = 7'b1110011; f3 = 3'b000; f7 = 7'($urandom);
        end
    endtask

    localparam logic [6:0] R = 7'b0110011;

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         hcnt;
        build_table();
        model_reset();
        @(posedge clk);
        #1;
        repeat (3) step(1'b1, 1'b0, '0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);

        ins(R, 3'b000, 7'h00, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);

        ins(R, 3'b000, 7'h01, 1'b0);
        repeat (3) ins(R, 3'b000, 7'h20, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);

        ins(R, 3'b100, 7'h01, 1'b0);
        repeat (4) ins(R, 3'b000, 7'h00, 1'b0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0);
        ins(R, 3'b000, 7'h00, 1'b0);
        ins(R, 3'b110, 7'h01, 1'b0);
        repeat (8) ins(R, 3'b111, 7'h00, 1'b0);

        ins(7'b1100011, 3'b000, 7'h00, 1'b1);
        ins(7'b1100011, 3'b001, 7'h00, 1'b0);
        ins(7'b0100011, 3'b010, 7'h11, 1'b0);
        ins(7'b0000011, 3'b010, 7'h22, 1'b0);
        ins(7'b0010011, 3'b000, 7'h7f, 1'b0);
        ins(R, 3'b000, 7'h01, 1'b1);
        ins(R, 3'b001, 7'h00, 1'b0);

        ins(7'b1110011, 3'b000, 7'h00, 1'b1);
        ins(7'b1110011, 3'b000, 7'h00, 1'b0);
        repeat (3) ins(R, 3'b000, 7'h00, 1'b0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0);

        ins(7'b1111111, 3'b000, 7'h00, 1'b1);
        ins(7'b1111111, 3'b000, 7'h00, 1'b0);
        repeat (3) ins(R, 3'b000, 7'h00, 1'b0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0);

        hcnt = 0;
        for (int c = 0; c < 800; c++) begin
            if (m_halt) hcnt++;
            else hcnt = 0;
            if (hcnt >= 3 || $urandom_range(0, 99) == 0) begin
                step(1'b1, 1'b0, '0, '0, '0, 1'b0);
                hcnt = 0;
            end else begin
                rand_instr(op, f3, f7);
                step(1'b0, $urandom_range(0, 9) != 0, op, f3, f7, $urandom_range(0, 11) == 0);
            end
        end
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);

        // M extension disabled: MUL traps as illegal and halts permanently.
        n_reset = 1'b0;
        chk("nm_reset_halted", {31'd0, n_halted}, 0);
        chk("nm_reset_valid", {31'd0, n_valid}, 0);
        n_dv = 1'b1; n_op = R; n_f3 = 3'b000; n_f7 = 7'h01;
        @(posedge clk);
        #1;
        chk("nm_illegal", {31'd0, n_ill}, 1);
        chk("nm_function", {28'd0, n_fn}, 32'hF);
        chk("nm_reg_write", {31'd0, n_rw}, 0);
        chk("nm_valid", {31'd0, n_valid}, 1);
        chk("nm_halted", {31'd0, n_halted}, 1);
        n_f7 = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("nm_halt_sticky", {31'd0, n_halted}, 1);
        chk("nm_stall_sticky", {31'd0, n_stall}, 1);
        chk("nm_bubble_valid", {31'd0, n_valid}, 0);
        chk("nm_bubble_func", {28'd0, n_fn}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
